// File: rtl/reg_bank_mc.sv
// reg_bank_mc: per-channel control/command/status/event register bank with masked interrupt
module reg_bank_mc #(
  parameter int NCH    = 4,
  parameter int CTRL_W = 8,
  parameter int STAT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    wr_en,
  input  logic [15:0]             addr,
  input  logic [3:0]              be,
  input  logic [31:0]             wr_data,
  input  logic                    rd_en,
  output logic                    rd_rdy,
  output logic [31:0]             rd_data,
  output logic [NCH*CTRL_W-1:0]   ctrl,
  output logic [NCH-1:0]          start_pulse,
  output logic [NCH-1:0]          stop_pulse,
  input  logic [NCH*STAT_W-1:0]   status_in,
  output logic                    irq
);
  logic [CTRL_W-1:0]     ctrl_r [NCH];
  logic [STAT_W-1:0]     evt_r  [NCH];
  logic [NCH-1:0]        irq_en_r, pending, ctrl_wr, cmd_wr, evt_wr;
  logic [NCH*STAT_W-1:0] stat_prev, rise;
  logic [31:0]           bmask, wmask, rd_val;
  logic                  irq_en_wr;
  assign bmask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wmask     = wr_data & bmask;
  assign rise      = status_in & ~stat_prev;
  assign irq_en_wr = wr_en && addr == 16'hFF00;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ctrl[i*CTRL_W +: CTRL_W] = ctrl_r[i];
    assign pending[i]               = |evt_r[i];
  end
  // Read mux sees pre-write register values, so a coincident write never leaks into the read
  always_comb begin
    rd_val  = '0;
    ctrl_wr = '0;
    cmd_wr  = '0;
    evt_wr  = '0;
    for (int n = 0; n < NCH; n++) begin
      if (addr[15:4] == 12'(n)) begin
        rd_val = addr[3:0] == 4'h0 ? 32'(ctrl_r[n]) :
                 addr[3:0] == 4'h8 ? 32'(status_in[n*STAT_W +: STAT_W]) :
                 addr[3:0] == 4'hC ? 32'(evt_r[n]) : 32'd0;
        ctrl_wr[n] = wr_en && addr[3:0] == 4'h0;
        cmd_wr[n]  = wr_en && addr[3:0] == 4'h4;
        evt_wr[n]  = wr_en && addr[3:0] == 4'hC;
      end
    end
    if (addr == 16'hFF00) rd_val = 32'(irq_en_r);
    if (addr == 16'hFF04) rd_val = 32'(pending);
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int n = 0; n < NCH; n++) begin
        ctrl_r[n] <= '0;
        evt_r[n]  <= '0;
      end
      irq_en_r    <= '0;
      stat_prev   <= '0;
      start_pulse <= '0;
      stop_pulse  <= '0;
      irq         <= 1'b0;
      rd_rdy      <= 1'b0;
      rd_data     <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (ctrl_wr[n]) ctrl_r[n] <= CTRL_W'((32'(ctrl_r[n]) & ~bmask) | wmask);
        evt_r[n] <= (evt_r[n] & ~STAT_W'(evt_wr[n] ? wmask : 32'd0)) | rise[n*STAT_W +: STAT_W];
      end
      if (irq_en_wr) irq_en_r <= NCH'((32'(irq_en_r) & ~bmask) | wmask);
      stat_prev   <= status_in;
      start_pulse <= cmd_wr & {NCH{wr_data[0] & be[0]}};
      stop_pulse  <= cmd_wr & {NCH{wr_data[8] & be[1]}};
      irq         <= |(irq_en_r & pending);
      rd_rdy      <= rd_en;
      if (rd_en) rd_data <= rd_val;
    end
  end
endmodule

// File: tb/tb_reg_bank_mc.sv
// tb_reg_bank_mc: table-driven register bank checks with a read-data scoreboard
module tb_reg_bank_mc;
  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic        rd_rdy;
  logic [31:0] rd_data;
  logic [31:0] ctrl;
  logic [3:0]  start_pulse, stop_pulse;
  logic [31:0] status_in = '0;
  logic        irq;
  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q [$];
  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] e;
  } rec_t;
  rec_t vec [$];
  reg_bank_mc #(.NCH(4), .CTRL_W(8), .STAT_W(8)) dut (
    .clk(clk), .rstb(rstb), .wr_en(wr_en), .addr(addr), .be(be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_rdy(rd_rdy), .rd_data(rd_data), .ctrl(ctrl),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .status_in(status_in), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (rstb && rd_rdy) begin
      if (exp_q.size() == 0) chk("rd_rdy_unexpected", 32'(rd_rdy), 32'd0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_en = 1'b1; addr = a; be = b; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] e);
    rd_en = 1'b1; addr = a; be = 4'h0;
    exp_q.push_back(e);
    cyc();
    rd_en = 1'b0;
  endtask
  function automatic void add(bit w, logic [15:0] a, logic [3:0] b, logic [31:0] d, logic [31:0] e);
    vec.push_back('{w, a, b, d, e});
  endfunction
  initial begin
    add(1, 16'h0010, 4'hF, 32'h0000_00A5, 0);
    add(0, 16'h0010, 4'h0, 0, 32'h0000_00A5);
    add(0, 16'h0000, 4'h0, 0, 32'h0);
    add(1, 16'h0030, 4'h2, 32'h0000_5A00, 0);
    add(0, 16'h0030, 4'h0, 0, 32'h0);
    add(1, 16'h0030, 4'h1, 32'hFFFF_FF3C, 0);
    add(0, 16'h0030, 4'h0, 0, 32'h3C);
    add(1, 16'h0010, 4'h0, 32'h0000_0011, 0);
    add(0, 16'h0010, 4'h0, 0, 32'hA5);
    add(1, 16'h1010, 4'hF, 32'h0000_00FF, 0);
    add(0, 16'h0010, 4'h0, 0, 32'hA5);
    add(0, 16'h1010, 4'h0, 0, 32'h0);
    add(1, 16'h0040, 4'hF, 32'h0000_00FF, 0);
    add(0, 16'h0000, 4'h0, 0, 32'h0);
    add(1, 16'hFF00, 4'hF, 32'hFFFF_FFFF, 0);
    add(0, 16'hFF00, 4'h0, 0, 32'hF);
    add(1, 16'hFF00, 4'h1, 32'h0000_0002, 0);
    add(0, 16'hFF00, 4'h0, 0, 32'h2);
    add(0, 16'h0040, 4'h0, 0, 32'h0);
    add(0, 16'h0004, 4'h0, 0, 32'h0);
    add(0, 16'h0014, 4'h0, 0, 32'h0);
    add(0, 16'h0011, 4'h0, 0, 32'h0);
    add(0, 16'hFF04, 4'h0, 0, 32'h0);
    add(0, 16'h0018, 4'h0, 0, 32'h0);
    add(0, 16'h001C, 4'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", ctrl, 32'h0);
    chk("rst_pulses", {24'd0, start_pulse, stop_pulse}, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rd_rdy", 32'(rd_rdy), 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    rstb = 1'b1;
    cyc();
    foreach (vec[i]) begin
      if (vec[i].w) wr(vec[i].a, vec[i].b, vec[i].d);
      else rd(vec[i].a, vec[i].e);
    end
    chk("ctrl_bus", ctrl, 32'h3C00_A500);
    // command pulses
    wr(16'h0024, 4'h1, 32'h0000_0101);
    chk("start_be1", 32'(start_pulse), 32'h4);
    chk("stop_be1", 32'(stop_pulse), 32'h0);
    cyc();
    chk("start_once", 32'(start_pulse), 32'h0);
    wr(16'h0024, 4'h3, 32'h0000_0101);
    chk("start_be3", 32'(start_pulse), 32'h4);
    chk("stop_be3", 32'(stop_pulse), 32'h4);
    cyc();
    chk("pulses_end", {28'd0, start_pulse | stop_pulse}, 32'h0);
    wr_en = 1'b1; addr = 16'h0004; be = 4'h1; wr_data = 32'h1;
    cyc();
    chk("b2b_first", 32'(start_pulse), 32'h1);
    addr = 16'h0034;
    cyc();
    wr_en = 1'b0;
    chk("b2b_second", 32'(start_pulse), 32'h8);
    cyc();
    chk("b2b_end", 32'(start_pulse), 32'h0);
    // events and interrupt
    status_in = 32'h0000_0800;
    cyc();
    chk("irq_latency", 32'(irq), 32'h0);
    cyc();
    chk("irq_set", 32'(irq), 32'h1);
    rd(16'h001C, 32'h08);
    rd(16'h0018, 32'h08);
    rd(16'hFF04, 32'h2);
    rd(16'h001C, 32'h08);
    status_in = 32'h0001_0800;
    cyc();
    cyc();
    rd(16'hFF04, 32'h6);
    wr(16'h001C, 4'h1, 32'h0000_0008);
    chk("irq_hold_after_clr", 32'(irq), 32'h1);
    cyc();
    chk("irq_masked", 32'(irq), 32'h0);
    rd(16'h001C, 32'h0);
    wr(16'h002C, 4'hF, 32'hFFFF_FFFF);
    rd(16'hFF04, 32'h0);
    // set beats simultaneous clear
    status_in = 32'h0001_0801;
    wr(16'h000C, 4'h1, 32'h1);
    rd(16'h000C, 32'h1);
    wr(16'h000C, 4'h0, 32'h1);
    rd(16'h000C, 32'h1);
    wr(16'h000C, 4'h1, 32'h0);
    rd(16'h000C, 32'h1);
    wr(16'h000C, 4'h1, 32'h1);
    rd(16'h000C, 32'h0);
    // read during write returns old value, then hold
    wr_en = 1'b1; rd_en = 1'b1; addr = 16'h0010; be = 4'hF; wr_data = 32'h77;
    exp_q.push_back(32'hA5);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    rd(16'h0010, 32'h77);
    addr = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_rd_data", rd_data, 32'h77);
      chk("hold_rd_rdy", 32'(rd_rdy), 32'h0);
    end
    rd(16'h0040, 32'h0);
    // reset during pulse and rd_rdy
    status_in = 32'h0001_1801;
    cyc();
    cyc();
    chk("irq_pre_rst", 32'(irq), 32'h1);
    wr_en = 1'b1; rd_en = 1'b1; addr = 16'h0014; be = 4'h1; wr_data = 32'h1;
    exp_q.push_back(32'h0);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("pre_rst_start", 32'(start_pulse), 32'h2);
    chk("pre_rst_rd_rdy", 32'(rd_rdy), 32'h1);
    #1 rstb = 1'b0;
    #1;
    chk("mid_rst_start", 32'(start_pulse), 32'h0);
    chk("mid_rst_rd_rdy", 32'(rd_rdy), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_ctrl", ctrl, 32'h0);
    exp_q.delete();
    status_in = 32'h0000_0001;
    @(negedge clk);
    rstb = 1'b1;
    rd(16'h0000, 32'h0);
    rd(16'h0010, 32'h0);
    rd(16'h0020, 32'h0);
    rd(16'h0030, 32'h0);
    rd(16'hFF00, 32'h0);
    rd(16'h001C, 32'h0);
    rd(16'h000C, 32'h1);
    rd(16'hFF04, 32'h1);
    cyc();
    cyc();
    chk("post_rst_irq", 32'(irq), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
